// File: rtl/alu_op_sequencer.sv
// Sequences the shared ALU: one-hot op select, latency wait, result capture.
// Supports single-step issue and auto-run with a fixed dwell between ops.
module alu_op_sequencer #(
  parameter int NUM_OPS      = 9,
  parameter int ALU_LATENCY  = 1,
  parameter int DWELL_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        async_reset,
  input  logic        i_step,
  input  logic        i_run,
  input  logic        i_clear,
  input  logic [3:0]  i_left,
  input  logic [3:0]  i_right,
  input  logic        i_negative,
  output logic [15:0] o_selector,
  output logic [3:0]  o_op_index,
  output logic [3:0]  o_left,
  output logic [3:0]  o_right,
  output logic        o_negative,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_running
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DWELL   = 3'd4;

  localparam int DW =
    (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST =
    DW'(DWELL_CYCLES - 1);
  localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);
  localparam logic [3:0] LAT     = 4'(ALU_LATENCY);

  logic [2:0]    state;
  logic          issued;
  logic [3:0]    wait_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [3:0]    next_idx;
  logic          run_nxt;

  always_comb begin
    next_idx = 4'd0;
    if (issued && (o_op_index != LAST_OP))
      next_idx = o_op_index + 4'd1;
    run_nxt = o_running ^ i_run;
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state      <= S_IDLE;
      issued     <= 1'b0;
      wait_cnt   <= '0;
      dwell_cnt  <= '0;
      o_selector <= '0;
      o_op_index <= '0;
      o_left     <= '0;
      o_right    <= '0;
      o_negative <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_running  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        state      <= S_IDLE;
        issued     <= 1'b0;
        wait_cnt   <= '0;
        dwell_cnt  <= '0;
        o_selector <= '0;
        o_op_index <= '0;
        o_left     <= '0;
        o_right    <= '0;
        o_negative <= 1'b0;
        o_busy     <= 1'b0;
        o_running  <= 1'b0;
      end else begin
        o_running <= run_nxt;
        unique case (state)
          S_IDLE: begin
            if (i_run || (i_step && !o_running))
              state <= S_ISSUE;
          end
          S_ISSUE: begin
            o_op_index <= next_idx;
            o_selector <= 16'h0001 << next_idx;
            issued     <= 1'b1;
            o_busy     <= 1'b1;
            wait_cnt   <= LAT;
            state      <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == 4'd0)
              state <= S_CAPTURE;
            else
              wait_cnt <= wait_cnt - 4'd1;
          end
          S_CAPTURE: begin
            o_left     <= i_left;
            o_right    <= i_right;
            o_negative <= i_negative;
            o_valid    <= 1'b1;
            o_busy     <= 1'b0;
            dwell_cnt  <= '0;
            // run toggles seen this cycle decide the follow-on state
            state <= run_nxt ? S_DWELL : S_IDLE;
          end
          S_DWELL: begin
            if (i_run) begin
              state     <= S_IDLE;
              dwell_cnt <= '0;
            end else if (dwell_cnt == DWELL_LAST) begin
              state     <= S_ISSUE;
              dwell_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
